alu_result_display: RTL and testbench

//   Display-side consumer of the ALU result bus: captures the decimal tens/units

---
 rtl/alu_result_display.sv | 210 +++++++++++++++++++++
 tb/tb_alu_result_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
//   Display-side consumer of the ALU result bus. On a load strobe it captures
//   the decimal tens/units digits and the zero/error flags, then drives a
//   time-multiplexed 2-digit common-cathode 7-segment display. The tens digit
//   is blanked when it is zero. An error result shows a blinking "EE".
//
// Parameters
//   REFRESH_DIV : clk cycles each digit slot is lit (>= 2)
//   BLINK_DIV   : digit slots per blink half-period in error mode (>= 1)
//
// Ports
//   clk       in   1  clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   load      in   1  capture strobe, sampled every rising edge
//   dec_bin   in   4  tens digit (0-9 valid)
//   unis_bin  in   4  units digit (0-9 valid)
//   zero      in   1  result-is-zero flag
//   error     in   1  error flag
//   seg       out  7  segments, active-high, seg[0]=a .. seg[6]=g
//   dig_en    out  2  digit enables, [0]=units, [1]=tens, never both set
//   zero_led  out  1  captured zero flag
//   err_led   out  1  captured error flag
// -----------------------------------------------------------------------------
module alu_result_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] dec_bin,
    input  logic [3:0] unis_bin,
    input  logic       zero,
    input  logic       error,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       zero_led,
    output logic       err_led
);

    localparam int RW = $clog2(REFRESH_DIV);
    // A one-slot blink period still needs a one-bit counter to exist.
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_E    = 7'b1111001;
    localparam logic [6:0] SEG_DARK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_UNITS = 2'd1,
        ST_TENS  = 2'd2
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   refresh_cnt_r;
    logic [BW-1:0]   blink_cnt_r;
    logic            blink_on_r;
    logic [3:0]      units_r;
    logic [3:0]      tens_r;
    logic            slot_toggle_s;
    logic [6:0]      seg_next_s;
    logic [1:0]      dig_en_next_s;

    // BCD digit to segment pattern; out-of-range codes show a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = 7'b1000000;
        endcase
        return pattern;
    endfunction

    // The slot flips on the last refresh count; never in BLANK.
    assign slot_toggle_s = (state_r != ST_BLANK) && (refresh_cnt_r == REFRESH_LAST);

    // Slot FSM and refresh counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_BLANK;
            refresh_cnt_r <= {RW{1'b0}};
        end else begin
            case (state_r)
                ST_BLANK: begin
                    refresh_cnt_r <= {RW{1'b0}};
                    if (load) begin
                        state_r <= ST_UNITS;
                    end else begin
                        state_r <= ST_BLANK;
                    end
                end
                ST_UNITS: begin
                    if (slot_toggle_s) begin
                        state_r       <= ST_TENS;
                        refresh_cnt_r <= {RW{1'b0}};
                    end else begin
                        refresh_cnt_r <= refresh_cnt_r + RW'(1);
                    end
                end
                ST_TENS: begin
                    if (slot_toggle_s) begin
                        state_r       <= ST_UNITS;
                        refresh_cnt_r <= {RW{1'b0}};
                    end else begin
                        refresh_cnt_r <= refresh_cnt_r + RW'(1);
                    end
                end
                default: begin
                    state_r       <= ST_BLANK;
                    refresh_cnt_r <= {RW{1'b0}};
                end
            endcase
        end
    end

    // Result capture on the load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units_r  <= 4'd0;
            tens_r   <= 4'd0;
            zero_led <= 1'b0;
            err_led  <= 1'b0;
        end else if (load) begin
            units_r  <= unis_bin;
            tens_r   <= dec_bin;
            zero_led <= zero;
            err_led  <= error;
        end
    end

    // Blink phase: counts slot toggles while an error is displayed; a load
    // restarts the phase so a fresh error always begins visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (load || !err_led) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= 1'b1;
        end else if (slot_toggle_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= {BW{1'b0}};
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
        end
    end

    // Next display pattern from the captured state.
    always_comb begin
        seg_next_s    = SEG_DARK;
        dig_en_next_s = 2'b00;
        case (state_r)
            ST_BLANK: begin
                seg_next_s    = SEG_DARK;
                dig_en_next_s = 2'b00;
            end
            ST_UNITS: begin
                if (err_led) begin
                    seg_next_s    = blink_on_r ? SEG_E : SEG_DARK;
                    dig_en_next_s = blink_on_r ? 2'b01 : 2'b00;
                end else begin
                    seg_next_s    = decode_digit(units_r);
                    dig_en_next_s = 2'b01;
                end
            end
            ST_TENS: begin
                if (err_led) begin
                    seg_next_s    = blink_on_r ? SEG_E : SEG_DARK;
                    dig_en_next_s = blink_on_r ? 2'b10 : 2'b00;
                end else if (tens_r == 4'd0) begin
                    seg_next_s    = SEG_DARK;
                    dig_en_next_s = 2'b00;
                end else begin
                    seg_next_s    = decode_digit(tens_r);
                    dig_en_next_s = 2'b10;
                end
            end
            default: begin
                seg_next_s    = SEG_DARK;
                dig_en_next_s = 2'b00;
            end
        endcase
    end

    // Registered segment and digit-enable outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg    <= 7'd0;
            dig_en <= 2'b00;
        end else begin
            seg    <= seg_next_s;
            dig_en <= dig_en_next_s;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// -----------------------------------------------------------------------------
// tb_alu_result_display
//   Directed bench for alu_result_display with REFRESH_DIV=4, BLINK_DIV=2.
//   Each check compares {seg, dig_en, zero_led, err_led} against a
//   hand-computed value, sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] dec_bin;
    logic [3:0] unis_bin;
    logic       zero;
    logic       error;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       zero_led;
    logic       err_led;

    int tests = 0;
    int fails = 0;

    alu_result_display #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .dec_bin (dec_bin),
        .unis_bin(unis_bin),
        .zero    (zero),
        .error   (error),
        .seg     (seg),
        .dig_en  (dig_en),
        .zero_led(zero_led),
        .err_led (err_led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] expv);
        logic [10:0] obs;
        obs = {seg, dig_en, zero_led, err_led};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed={seg=%b dig_en=%b z=%b e=%b} expected={seg=%b dig_en=%b z=%b e=%b}",
                   tag, obs[10:4], obs[3:2], obs[1], obs[0],
                   expv[10:4], expv[3:2], expv[1], expv[0]);
        end
    endtask

    task automatic expect_n(input string tag, input logic [10:0] expv, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, expv);
        end
    endtask

    task automatic load_data(input logic [3:0] d, input logic [3:0] u,
                             input logic z, input logic e);
        dec_bin  = d;
        unis_bin = u;
        zero     = z;
        error    = e;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_reset();
        load  = 1'b0;
        reset = 1'b1;
        tick();
        check("reset_held", 11'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        dec_bin  = 4'd0;
        unis_bin = 4'd0;
        zero     = 1'b0;
        error    = 1'b0;
        tick();
        check("reset_state", 11'd0);
        tick();
        reset = 1'b0;

        // 1: no load -> dark
        expect_n("idle_dark", 11'd0, 100);

        // 2: "42" alternating every 4 cycles, 1-cycle latency
        do_reset();
        load_data(4'd4, 4'd2, 1'b0, 1'b0);
        check("t2_latency", 11'd0);
        expect_n("t2_units", {7'b1011011, 2'b01, 1'b0, 1'b0}, 4);
        expect_n("t2_tens",  {7'b1100110, 2'b10, 1'b0, 1'b0}, 4);
        expect_n("t2_units2", {7'b1011011, 2'b01, 1'b0, 1'b0}, 4);

        // 3: leading-zero blanking
        do_reset();
        load_data(4'd0, 4'd7, 1'b0, 1'b0);
        check("t3_latency", 11'd0);
        expect_n("t3_units", {7'b0000111, 2'b01, 1'b0, 1'b0}, 4);
        expect_n("t3_tens_blank", 11'd0, 4);
        expect_n("t3_units2", {7'b0000111, 2'b01, 1'b0, 1'b0}, 4);

        // 4: error blink "EE" 8 on / 8 off, then recover to "10"
        do_reset();
        load_data(4'd15, 4'd15, 1'b0, 1'b1);
        check("t4_latency", {7'b0000000, 2'b00, 1'b0, 1'b1});
        expect_n("t4_e_units", {7'b1111001, 2'b01, 1'b0, 1'b1}, 4);
        expect_n("t4_e_tens",  {7'b1111001, 2'b10, 1'b0, 1'b1}, 4);
        expect_n("t4_dark",    {7'b0000000, 2'b00, 1'b0, 1'b1}, 8);
        expect_n("t4_e_units2", {7'b1111001, 2'b01, 1'b0, 1'b1}, 4);
        expect_n("t4_e_tens2",  {7'b1111001, 2'b10, 1'b0, 1'b1}, 4);
        load_data(4'd1, 4'd0, 1'b0, 1'b0);
        check("t4_clear_lat", 11'd0);
        expect_n("t4_rec_units", {7'b0111111, 2'b01, 1'b0, 1'b0}, 3);
        expect_n("t4_rec_tens",  {7'b0000110, 2'b10, 1'b0, 1'b0}, 4);

        // 5: out-of-range tens, zero flag, then load on a toggle edge
        do_reset();
        load_data(4'd12, 4'd3, 1'b1, 1'b0);
        check("t5_latency", {7'b0000000, 2'b00, 1'b1, 1'b0});
        expect_n("t5_units", {7'b1001111, 2'b01, 1'b1, 1'b0}, 4);
        expect_n("t5_tens_dash", {7'b1000000, 2'b10, 1'b1, 1'b0}, 4);
        expect_n("t5_units2", {7'b1001111, 2'b01, 1'b1, 1'b0}, 3);
        load_data(4'd5, 4'd8, 1'b0, 1'b0);
        check("t5_toggle_lat", {7'b1001111, 2'b01, 1'b0, 1'b0});
        expect_n("t5_new_tens",  {7'b1101101, 2'b10, 1'b0, 1'b0}, 4);
        expect_n("t5_new_units", {7'b1111111, 2'b01, 1'b0, 1'b0}, 4);

        // 6: async reset mid-TENS, dark until next load
        do_reset();
        load_data(4'd4, 4'd2, 1'b0, 1'b0);
        check("t6_latency", 11'd0);
        expect_n("t6_units", {7'b1011011, 2'b01, 1'b0, 1'b0}, 4);
        expect_n("t6_tens",  {7'b1100110, 2'b10, 1'b0, 1'b0}, 2);
        reset = 1'b1;
        #1;
        check("t6_async_clear", 11'd0);
        tick();
        tick();
        reset = 1'b0;
        expect_n("t6_stay_dark", 11'd0, 20);
        load_data(4'd9, 4'd0, 1'b0, 1'b0);
        check("t6_reload_lat", 11'd0);
        expect_n("t6_units0", {7'b0111111, 2'b01, 1'b0, 1'b0}, 4);
        expect_n("t6_tens9",  {7'b1101111, 2'b10, 1'b0, 1'b0}, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
